cache_arbiter: RTL and testbench
================================

CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-002 SHALL have parameter LINE_W, default 256, cache line width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports i_read  input  1 / i_addr  input  ADDR_W / i_rdata  output  LINE_W / i_resp  output  1  I-cache line fill channel.
REQ-006 SHALL have ports d_read  input  1 / d_write  input  1 / d_addr  input  ADDR_W / d_wdata  input  LINE_W / d_rdata  output  LINE_W / d_resp  output  1  D-cache fill/writeback channel.
REQ-007 SHALL have ports pmem_read  output  1 / pmem_write  output  1 / pmem_addr  output  ADDR_W / pmem_wdata  output  LINE_W / pmem_rdata  input  LINE_W / pmem_resp  input  1  shared physical memory port.

Function
REQ-008 SHALL implement FSM states IDLE, SERVE_I, SERVE_D, RESP_I, RESP_D.
REQ-009 SHALL in IDLE, when any request is high, grant one requester, latch its address, write data and direction, and move to SERVE_I or SERVE_D on the next edge.
REQ-010 SHALL drive pmem_read/pmem_write from registered state only; they are asserted from the first SERVE cycle until pmem_resp is sampled high.
REQ-011 SHALL drive pmem_addr = latched address with bits [log2(LINE_W/8)-1:0] forced to zero (line-aligned; 5 bits at default).
REQ-012 SHALL, on pmem_resp in SERVE_x, latch pmem_rdata and go to RESP_x; in RESP_x assert x_resp for exactly one cycle with x_rdata valid; then return to IDLE.
REQ-013 SHALL give latency: request sampled in IDLE at cycle N -> pmem command at N+1; pmem_resp at cycle M -> x_resp at M+1; next grant sampled no earlier than M+2.
REQ-014 SHALL hold i_rdata/d_rdata at last latched value outside RESP cycles; x_resp is never high for the non-granted requester.
REQ-015 SHALL treat d_read and d_write both high as a write (d_write wins).
REQ-016 SHALL ignore request changes while in SERVE_x/RESP_x; latched values are used for the whole transaction.
REQ-017 SHALL ignore pmem_resp in IDLE and RESP states.
REQ-018 SHALL never assert pmem_read and pmem_write simultaneously.
REQ-019 SHALL require requesters to hold request and address stable until x_resp and to deassert on the cycle after x_resp.

Reset
REQ-020 SHALL on rst_n low immediately force state IDLE and all outputs to 0 (pmem_read, pmem_write, i_resp, d_resp, pmem_addr, pmem_wdata, i_rdata, d_rdata).
REQ-021 SHALL on reset mid-transaction abandon it; no x_resp is produced for it after rst_n rises.
REQ-022 SHALL reset the last-grant register to "I" (D-cache wins first tie).

Configuration
REQ-023 SHALL, with CACHE_ARB_ROUND_ROBIN_EN defined, resolve simultaneous I/D requests in IDLE in favour of the requester not granted last; last-grant updates at each grant.
REQ-024 SHALL, without CACHE_ARB_ROUND_ROBIN_EN, always grant D-cache on simultaneous requests (fixed priority); last-grant register not implemented.

Verification
REQ-025 SHALL verify single I read: i_read=1, i_addr=0x0000_1234, pmem_resp after 3 cycles with data 0xA5..A5 -> pmem_addr=0x0000_1220, pmem_read for 3 cycles, i_resp one cycle later, i_rdata=0xA5..A5.
REQ-026 SHALL verify D write: d_write=1, d_addr=0x8000_0040, d_wdata=0x1..1 -> pmem_write=1, pmem_wdata=0x1..1, pmem_read=0, d_resp one cycle after pmem_resp.
REQ-027 SHALL verify tie: i_read and d_read asserted same cycle, held, twice in succession -> fixed: D, D...; round-robin: D then I.
REQ-028 SHALL verify d_read=d_write=1 -> pmem_write only.
REQ-029 SHALL verify rst_n pulsed low during SERVE_D -> all outputs 0 asynchronously, no d_resp afterwards, next request served normally.
REQ-030 SHALL verify spurious pmem_resp in IDLE -> no x_resp, no state change.

Source files
------------

// File: rtl/cache_arbiter.sv
// cache_arbiter: arbitrates I-cache line fills and D-cache fills/writebacks onto one memory port.
// Define CACHE_ARB_ROUND_ROBIN_EN for round-robin ties; default is fixed D-cache priority.
module cache_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((LINE_W / 8) - 1);

    typedef enum logic [2:0] {IDLE, SERVE_I, SERVE_D, RESP_I, RESP_D} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
    logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
    logic              wr_q, wr_d;
    logic              d_req, grant_d;

    assign d_req = d_read | d_write;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
    // last_q high means the D-cache won the previous grant
    logic last_q, last_d;
    assign grant_d = d_req && (!i_read || !last_q);
    assign last_d  = (state_q == IDLE && (i_read || d_req)) ? grant_d : last_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) last_q <= 1'b0;
        else        last_q <= last_d;
`else
    assign grant_d = d_req;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_q      <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wr_q      <= wr_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_d      = wr_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        case (state_q)
            IDLE: if (i_read || d_req) begin
                state_d = grant_d ? SERVE_D : SERVE_I;
                addr_d  = grant_d ? d_addr : i_addr;
                wr_d    = grant_d && d_write;
                wdata_d = (grant_d && d_write) ? d_wdata : '0;
            end
            SERVE_I: if (pmem_resp) begin
                i_rdata_d = pmem_rdata;
                state_d   = RESP_I;
            end
            SERVE_D: if (pmem_resp) begin
                d_rdata_d = pmem_rdata;
                state_d   = RESP_D;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pmem_read  = (state_q == SERVE_I || state_q == SERVE_D) && !wr_q;
        pmem_write = (state_q == SERVE_I || state_q == SERVE_D) && wr_q;
        pmem_addr  = addr_q & ~OFF_MASK;
        pmem_wdata = wdata_q;
        i_resp     = state_q == RESP_I;
        d_resp     = state_q == RESP_D;
        i_rdata    = i_rdata_q;
        d_rdata    = d_rdata_q;
    end
endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed self-checking bench for cache_arbiter.
module tb_cache_arbiter;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_read = 1'b0, d_read = 1'b0, d_write = 1'b0, pmem_resp = 1'b0;
    logic [31:0]  i_addr = '0, d_addr = '0;
    logic [255:0] d_wdata = '0, pmem_rdata = '0;
    logic [255:0] i_rdata, d_rdata, pmem_wdata;
    logic [31:0]  pmem_addr;
    logic         i_resp, d_resp, pmem_read, pmem_write;
    int checks = 0, errors = 0;

    localparam logic [255:0] A5 = {32{8'hA5}};
    localparam logic [255:0] ONES = {64{4'h1}};
    localparam logic [255:0] C3 = {32{8'hC3}};

    cache_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic run_txn(input string nm, input logic ir, dr, dw,
                           input logic [31:0] ia, da, input logic [255:0] wd, rd,
                           input int lat, input logic exp_d, exp_wr);
        logic [31:0] ea;
        int n_cmd;
        ea = (exp_d ? da : ia) & 32'hFFFF_FFE0;
        n_cmd = 0;
        i_read = ir; d_read = dr; d_write = dw; i_addr = ia; d_addr = da; d_wdata = wd;
        tick();
        for (int c = 1; c <= lat; c++) begin
            if (pmem_read === !exp_wr && pmem_write === exp_wr) n_cmd++;
            checks++;
            if (pmem_addr !== ea) begin
                errors++;
                $display("FAIL %s addr c%0d: got %h want %h", nm, c, pmem_addr, ea);
            end
            checks++;
            if (i_resp !== 1'b0 || d_resp !== 1'b0) begin
                errors++;
                $display("FAIL %s early resp c%0d: got i=%b d=%b want 0 0", nm, c, i_resp, d_resp);
            end
            if (exp_wr) begin
                checks++;
                if (pmem_wdata !== wd) begin
                    errors++;
                    $display("FAIL %s wdata: got %h want %h", nm, pmem_wdata, wd);
                end
            end
            if (c == lat) begin pmem_resp = 1'b1; pmem_rdata = rd; end
            i_read = ir; d_read = dr;
            tick();
        end
        pmem_resp = 1'b0;
        checks++;
        if (n_cmd != lat) begin
            errors++;
            $display("FAIL %s cmd cycles: got %0d want %0d (read/write=%b/%b)", nm, n_cmd, lat, !exp_wr, exp_wr);
        end
        checks++;
        if (i_resp !== !exp_d || d_resp !== exp_d || pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
            errors++;
            $display("FAIL %s resp: got i=%b d=%b rd=%b wr=%b want i=%b d=%b rd=0 wr=0",
                     nm, i_resp, d_resp, pmem_read, pmem_write, !exp_d, exp_d);
        end
        if (!exp_wr) begin
            checks++;
            if ((exp_d ? d_rdata : i_rdata) !== rd) begin
                errors++;
                $display("FAIL %s rdata: got %h want %h", nm, exp_d ? d_rdata : i_rdata, rd);
            end
        end
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        tick();
        checks++;
        if (i_resp !== 1'b0 || d_resp !== 1'b0) begin
            errors++;
            $display("FAIL %s resp width: got i=%b d=%b want 0 0", nm, i_resp, d_resp);
        end
        if (!exp_wr) begin
            checks++;
            if ((exp_d ? d_rdata : i_rdata) !== rd) begin
                errors++;
                $display("FAIL %s rdata hold: got %h want %h", nm, exp_d ? d_rdata : i_rdata, rd);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0 || pmem_addr !== '0 ||
            pmem_wdata !== '0 || i_rdata !== '0 || d_rdata !== '0) begin
            errors++;
            $display("FAIL reset outputs: got rd=%b wr=%b ir=%b dr=%b addr=%h want all zero",
                     pmem_read, pmem_write, i_resp, d_resp, pmem_addr);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_i_read();
        run_txn("i_read", 1'b1, 1'b0, 1'b0, 32'h0000_1234, '0, '0, A5, 3, 1'b0, 1'b0);
    endtask

    task automatic test_d_write();
        run_txn("d_write", 1'b0, 1'b0, 1'b1, '0, 32'h8000_0040, ONES, '0, 2, 1'b1, 1'b1);
    endtask

    task automatic test_d_read_write();
        run_txn("d_rw", 1'b0, 1'b1, 1'b1, '0, 32'h0000_00FF, C3, '0, 1, 1'b1, 1'b1);
    endtask

    task automatic test_tie();
        do_reset();
        run_txn("tie1", 1'b1, 1'b1, 1'b0, 32'h0000_2000, 32'h0000_3000, '0, C3, 2, 1'b1, 1'b0);
`ifdef CACHE_ARB_ROUND_ROBIN_EN
        run_txn("tie2", 1'b1, 1'b1, 1'b0, 32'h0000_2000, 32'h0000_3000, '0, A5, 2, 1'b0, 1'b0);
`else
        run_txn("tie2", 1'b1, 1'b1, 1'b0, 32'h0000_2000, 32'h0000_3000, '0, A5, 2, 1'b1, 1'b0);
`endif
    endtask

    task automatic test_back_to_back();
        run_txn("b2b_i", 1'b1, 1'b0, 1'b0, 32'h0000_4444, '0, '0, ONES, 1, 1'b0, 1'b0);
        run_txn("b2b_d", 1'b0, 1'b1, 1'b0, '0, 32'h0000_5555, '0, A5, 1, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        d_read = 1'b1; d_addr = 32'h0000_6000;
        tick();
        checks++;
        if (pmem_read !== 1'b1) begin
            errors++;
            $display("FAIL mid setup: got pmem_read=%b want 1", pmem_read);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0 || pmem_addr !== '0 ||
            i_rdata !== '0 || d_rdata !== '0) begin
            errors++;
            $display("FAIL mid async: got rd=%b wr=%b addr=%h irdata=%h want all zero",
                     pmem_read, pmem_write, pmem_addr, i_rdata);
        end
        d_read = 1'b0;
        pmem_resp = 1'b1; pmem_rdata = A5;
        #2 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (d_resp !== 1'b0 || i_resp !== 1'b0 || d_rdata !== '0) begin
                errors++;
                $display("FAIL mid no resp c%0d: got d=%b i=%b drdata=%h want 0 0 0", k, d_resp, i_resp, d_rdata);
            end
        end
        pmem_resp = 1'b0;
        run_txn("after_rst", 1'b0, 1'b1, 1'b0, '0, 32'h0000_6010, '0, C3, 2, 1'b1, 1'b0);
    endtask

    task automatic test_spurious();
        pmem_resp = 1'b1; pmem_rdata = ONES;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if ({i_resp, d_resp, pmem_read, pmem_write} !== 4'b0 || d_rdata !== C3) begin
                errors++;
                $display("FAIL spurious c%0d: got resp=%b%b cmd=%b%b drdata=%h want 0000 %h",
                         k, i_resp, d_resp, pmem_read, pmem_write, d_rdata, C3);
            end
        end
        pmem_resp = 1'b0;
        run_txn("post_spur", 1'b1, 1'b0, 1'b0, 32'h0000_7777, '0, '0, A5, 1, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_i_read();
        test_d_write();
        test_d_read_write();
        test_tie();
        test_back_to_back();
        test_reset_mid();
        test_spurious();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
